// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one instruction-memory read per fetch, holds
// the returned word for the decoder until it is accepted, and discards
// responses or held instructions when a branch flush arrives.
// Optional feature: define IFETCH_TIMEOUT_EN to add a memory-response timeout
// that raises a sticky o_err and stops fetching.
module instr_fetch #(
  parameter int ADDR_W      = 64,
  parameter int INSTR_W     = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_sig,
  input  logic               end_sig,
  input  logic               i_flush,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_rvalid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_instr_pc,
  output logic               o_done,
  output logic               o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   req_pc;
  logic                flush_pending;
  logic                rsp_arrive;
  logic                rsp_drop;
  logic                rsp_take;
  logic                timeout;

  // A response is only meaningful in WAIT; a flush seen now or earlier in
  // this WAIT turns it into a discard.
  assign rsp_arrive = (state == S_WAIT) && i_imem_rvalid;
  assign rsp_drop   = rsp_arrive && (flush_pending || i_flush);
  assign rsp_take   = rsp_arrive && !rsp_drop;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Fires on the last of TIMEOUT_CYC consecutive WAIT cycles without data.
  assign timeout = (state == S_WAIT) && !i_imem_rvalid &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Count WAIT cycles spent without a response; restart on any other cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if ((state == S_WAIT) && !i_imem_rvalid) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_err <= 1'b0;
    end else if (timeout) begin
      o_err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout            = 1'b0;
  assign o_err              = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (end_sig) begin
          state_nxt = S_DONE;
        end else if (start_sig) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: state_nxt = S_WAIT;
      S_WAIT: begin
        if (timeout) begin
          state_nxt = S_DONE;
        end else if (rsp_take) begin
          state_nxt = S_HOLD;
        end else if (rsp_drop) begin
          state_nxt = end_sig ? S_DONE : S_REQ;
        end
      end
      S_HOLD: begin
        // Flush outranks the handshake: the held word is treated as unused.
        if (i_flush || i_ready) begin
          if (end_sig) begin
            state_nxt = S_DONE;
          end else if (i_flush || start_sig) begin
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    o_imem_req  = (state == S_REQ);
    o_imem_addr = (state == S_REQ) ? i_pc : '0;
    o_done      = (state == S_DONE);
  end

  // Request PC capture, flush tracking and the held instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_pc        <= '0;
      flush_pending <= 1'b0;
      o_valid       <= 1'b0;
      o_instr       <= '0;
      o_instr_pc    <= '0;
    end else begin
      if (state == S_REQ) begin
        req_pc <= i_pc;
      end

      if ((state == S_WAIT) && !i_imem_rvalid && !timeout) begin
        flush_pending <= flush_pending | i_flush;
      end else begin
        flush_pending <= 1'b0;
      end

      if (rsp_take) begin
        o_valid    <= 1'b1;
        o_instr    <= i_imem_rdata;
        o_instr_pc <= req_pc;
      end else if ((state == S_HOLD) && (i_flush || i_ready)) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a vector table of fetches with varied
// response/ready delays, a scoreboard of instructions the decoder must see,
// and directed sequences for flush, end, timeout and reset corner cases.
module tb_instr_fetch;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  logic               clk;
  logic               reset;
  logic               start_sig;
  logic               end_sig;
  logic               i_flush;
  logic [ADDR_W-1:0]  i_pc;
  logic               o_imem_req;
  logic [ADDR_W-1:0]  o_imem_addr;
  logic               i_imem_rvalid;
  logic [INSTR_W-1:0] i_imem_rdata;
  logic               o_valid;
  logic               i_ready;
  logic [INSTR_W-1:0] o_instr;
  logic [ADDR_W-1:0]  o_instr_pc;
  logic               o_done;
  logic               o_err;

  instr_fetch #(
    .ADDR_W     (ADDR_W),
    .INSTR_W    (INSTR_W),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_sig    (start_sig),
    .end_sig      (end_sig),
    .i_flush      (i_flush),
    .i_pc         (i_pc),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata (i_imem_rdata),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_instr      (o_instr),
    .o_instr_pc   (o_instr_pc),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } exp_t;

  typedef struct {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] data;
    int                 rsp_delay;
    int                 ready_delay;
    int                 exp_waited;
    logic [INSTR_W-1:0] exp_instr;
    logic [ADDR_W-1:0]  exp_pc;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are checked on
  // the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Decoder-side monitor: a handshake happens at the coming rising edge.
  always @(negedge clk) begin
    if (!reset && o_valid && i_ready && !i_flush) begin
      if (sb_q.size() == 0) begin
        check("unexpected_handshake_pc", o_instr_pc, '1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_instr", {32'h0, o_instr}, {32'h0, e.instr});
        check("sb_pc", o_instr_pc, e.pc);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // Present pc and wait (bounded) for the read strobe carrying it.
  task automatic wait_req(input logic [ADDR_W-1:0] pc, output int waited);
    bit seen;
    i_pc   = pc;
    seen   = 1'b0;
    waited = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_imem_req) begin
        seen = 1'b1;
        break;
      end
      waited++;
    end
    check("req_seen", 64'(seen), 64'd1);
    check("req_addr", o_imem_addr, pc);
    check("no_valid_at_req", 64'(o_valid), 64'd0);
  endtask

  // One complete fetch: request, response after rsp_delay WAIT cycles,
  // ready_delay+1 stalled HOLD cycles, then the handshake.
  task automatic fetch_one(input logic [ADDR_W-1:0] pc, input logic [INSTR_W-1:0] data,
                           input int rsp_delay, input int ready_delay, output int waited);
    exp_t e;
    wait_req(pc, waited);
    for (int k = 0; k < rsp_delay; k++) begin
      next_cycle();
      @(negedge clk);
      check("wait_no_req", 64'(o_imem_req), 64'd0);
    end
    next_cycle();
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = data;
    e.instr = data;
    e.pc    = pc;
    sb_q.push_back(e);
    next_cycle();
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    @(negedge clk);
    check("valid_latency", 64'(o_valid), 64'd1);
    for (int k = 0; k < ready_delay; k++) begin
      next_cycle();
      @(negedge clk);
      check("hold_valid", 64'(o_valid), 64'd1);
      check("hold_instr", {32'h0, o_instr}, {32'h0, data});
      check("hold_pc", o_instr_pc, pc);
      check("hold_no_req", 64'(o_imem_req), 64'd0);
    end
    next_cycle();
    i_ready = 1'b1;
    next_cycle();
    i_ready = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    int req_cnt;

    vecs[0] = '{64'h0, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 64'h0};
    vecs[1] = '{64'h4, 32'h0BADC0DE, 0, 4, 0, 32'h0BADC0DE, 64'h4};
    vecs[2] = '{64'h8, 32'h12345678, 3, 1, 0, 32'h12345678, 64'h8};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFFFFFF, 1, 0, 0, 32'hFFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[4] = '{64'h10, 32'h0, 2, 2, 0, 32'h0, 64'h10};

    reset         = 1'b1;
    start_sig     = 1'b0;
    end_sig       = 1'b0;
    i_flush       = 1'b0;
    i_pc          = '0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    i_ready       = 1'b0;

    // Reset state, then IDLE holds while start_sig is low.
    do_reset();
    @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_req", 64'(o_imem_req), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    check("rst_instr", {32'h0, o_instr}, 64'd0);
    check("rst_instr_pc", o_instr_pc, 64'd0);
    next_cycle();
    @(negedge clk);
    check("idle_no_start", 64'(o_imem_req), 64'd0);
    next_cycle();
    start_sig = 1'b1;

    // Vector table: back-to-back fetches with start_sig held high.
    for (int i = 0; i < 5; i++) begin
      fetch_one(vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].rsp_delay, vecs[i].ready_delay, w);
      check("vec_req_wait", 64'(w), 64'(vecs[i].exp_waited));
    end
    check("sb_empty_vectors", 64'(sb_q.size()), 64'd0);

    // start_sig low: the outstanding fetch completes, then the FSM idles.
    start_sig = 1'b0;
    fetch_one(64'h20, 32'hA5A5A5A5, 1, 0, w);
    check("stop_req_wait", 64'(w), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stopped_no_req", 64'(o_imem_req), 64'd0);
      next_cycle();
    end
    start_sig = 1'b1;

    // Flush in WAIT: the late response is dropped, the next request uses the new PC.
    wait_req(64'h4, w);
    next_cycle();
    i_flush = 1'b1;
    next_cycle();
    i_flush = 1'b0;
    @(negedge clk);
    check("flush_wait_still_waiting", 64'(o_imem_req), 64'd0);
    next_cycle();
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'h11111111;
    next_cycle();
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    fetch_one(64'h40, 32'hCAFEF00D, 0, 0, w);
    check("flush_wait_reissue", 64'(w), 64'd0);

    // Flush coinciding with the handshake: flush wins, FSM re-requests.
    wait_req(64'h8, w);
    next_cycle();
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'h22222222;
    next_cycle();
    i_imem_rvalid = 1'b0;
    i_ready       = 1'b1;
    i_flush       = 1'b1;
    @(negedge clk);
    check("flush_hs_valid_before", 64'(o_valid), 64'd1);
    next_cycle();
    i_ready = 1'b0;
    i_flush = 1'b0;
    fetch_one(64'h80, 32'h33333333, 0, 0, w);
    check("flush_hs_reissue", 64'(w), 64'd0);
    check("sb_empty_flush", 64'(sb_q.size()), 64'd0);

    // end_sig at the handshake: done, and no requests for 20 cycles.
    end_sig = 1'b1;
    fetch_one(64'hC, 32'h44444444, 1, 2, w);
    @(negedge clk);
    check("end_done", 64'(o_done), 64'd1);
    req_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      i_imem_rvalid = (k == 3);
      @(negedge clk);
      if (o_imem_req) req_cnt++;
    end
    i_imem_rvalid = 1'b0;
    check("end_no_req_20", 64'(req_cnt), 64'd0);
    check("end_stray_rvalid", 64'(o_valid), 64'd0);
    check("end_done_held", 64'(o_done), 64'd1);
    end_sig = 1'b0;

    // Memory timeout.
    next_cycle();
    do_reset();
    @(negedge clk);
    check("rst2_done", 64'(o_done), 64'd0);
    next_cycle();
    wait_req(64'h100, w);
    for (int k = 0; k < 16; k++) next_cycle();
    @(negedge clk);
    check("to_err_before", 64'(o_err), 64'd0);
    check("to_done_before", 64'(o_done), 64'd0);
    next_cycle();
    @(negedge clk);
`ifdef IFETCH_TIMEOUT_EN
    check("to_err", 64'(o_err), 64'd1);
    check("to_done", 64'(o_done), 64'd1);
    next_cycle();
    @(negedge clk);
    check("to_err_sticky", 64'(o_err), 64'd1);
`else
    check("to_err", 64'(o_err), 64'd0);
    check("to_done", 64'(o_done), 64'd0);
    check("to_no_req", 64'(o_imem_req), 64'd0);
    next_cycle();
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'h55555555;
    sb_q.push_back('{32'h55555555, 64'h100});
    next_cycle();
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    @(negedge clk);
    check("to_late_valid", 64'(o_valid), 64'd1);
    next_cycle();
    i_ready = 1'b1;
    next_cycle();
    i_ready = 1'b0;
`endif

    // Reset mid-WAIT: the abandoned response must be ignored.
    start_sig = 1'b0;
    do_reset();
    start_sig = 1'b1;
    wait_req(64'h200, w);
    next_cycle();
    reset     = 1'b1;
    start_sig = 1'b0;
    next_cycle();
    reset         = 1'b0;
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'h66666666;
    next_cycle();
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    @(negedge clk);
    check("rst_wait_valid", 64'(o_valid), 64'd0);
    check("rst_wait_req", 64'(o_imem_req), 64'd0);
    check("rst_wait_done", 64'(o_done), 64'd0);
    check("rst_wait_instr_pc", o_instr_pc, 64'd0);

    check("sb_empty_final", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
